// File: rtl/ac_zone_ctrl.sv
// Multi-zone HVAC controller: one IDLE/HEAT/COOL/HOLD state machine per zone with dwell counters.
// Latency: temperature sampled at edge k is reflected on heating/cooling/active_cnt from edge k.
// Backpressure: none; pure sampled-input controller, every zone evaluated every cycle.
module ac_zone_ctrl #(
  parameter int NZONES  = 4,
  parameter int TW      = 5,
  parameter int MIN_ON  = 8,
  parameter int LOCKOUT = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [1:0]                    mode,
  input  logic [TW-1:0]                 heat_th,
  input  logic [TW-1:0]                 target,
  input  logic [TW-1:0]                 cool_th,
  input  logic [NZONES*TW-1:0]          temperature,
  output logic [NZONES-1:0]             heating,
  output logic [NZONES-1:0]             cooling,
  output logic [$clog2(NZONES+1)-1:0]   active_cnt,
  output logic                          cfg_err
);

  localparam int AW   = $clog2(NZONES+1);
  localparam int DMAX = (MIN_ON > LOCKOUT) ? MIN_ON : LOCKOUT;
  localparam int CW   = $clog2(DMAX+1);

  localparam logic [CW-1:0] ON_LAST   = CW'(MIN_ON-1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(LOCKOUT-1);
  localparam logic [CW-1:0] CNT_SAT   = {CW{1'b1}};

  typedef enum logic [1:0] {IDLE, HEAT, COOL, HOLD} zstate_t;

  zstate_t         st_q    [NZONES];
  zstate_t         st_d    [NZONES];
  logic [CW-1:0]   cnt_q   [NZONES];
  logic [CW-1:0]   cnt_d   [NZONES];
  logic [CW-1:0]   cnt_inc [NZONES];
  logic [TW-1:0]   temp_z  [NZONES];
  logic [AW-1:0]   act_d;

  logic cfg_ok;
  logic heat_ok;
  logic cool_ok;

  // Global permissions shared by every zone: a zone may only actuate while these hold.
  assign cfg_ok  = (heat_th < target) && (target < cool_th);
  assign heat_ok = enable && cfg_ok && mode[0];
  assign cool_ok = enable && cfg_ok && mode[1];

  for (genvar g = 0; g < NZONES; g++) begin : g_zone
    assign temp_z[g]  = temperature[g*TW +: TW];
    // Dwell counter saturates so a long HEAT/COOL stay cannot wrap and fake a short one.
    assign cnt_inc[g] = (cnt_q[g] == CNT_SAT) ? cnt_q[g] : cnt_q[g] + CW'(1);
  end

  // Next-state logic per zone; HEAT and COOL always pass through HOLD, never into each other.
  always_comb begin
    for (int i = 0; i < NZONES; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      case (st_q[i])
        IDLE: begin
          if (heat_ok && (temp_z[i] <= heat_th)) begin
            st_d[i]  = HEAT;
            cnt_d[i] = '0;
          end else if (cool_ok && (temp_z[i] >= cool_th)) begin
            st_d[i]  = COOL;
            cnt_d[i] = '0;
          end
        end
        HEAT: begin
          if (!heat_ok || ((temp_z[i] >= target) && (cnt_q[i] >= ON_LAST))) begin
            st_d[i]  = HOLD;
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_inc[i];
          end
        end
        COOL: begin
          if (!cool_ok || ((temp_z[i] <= target) && (cnt_q[i] >= ON_LAST))) begin
            st_d[i]  = HOLD;
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_inc[i];
          end
        end
        HOLD: begin
          // Lockout always runs to completion regardless of enable/mode.
          if (cnt_q[i] >= HOLD_LAST) begin
            st_d[i]  = IDLE;
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_inc[i];
          end
        end
        default: begin
          st_d[i]  = IDLE;
          cnt_d[i] = '0;
        end
      endcase
    end
  end

  // Count zones that will be actuating after this edge, so active_cnt can be registered alongside them.
  always_comb begin
    act_d = '0;
    for (int i = 0; i < NZONES; i++) begin
      if ((st_d[i] == HEAT) || (st_d[i] == COOL)) begin
        act_d = act_d + AW'(1);
      end
    end
  end

  // State, counters and all outputs registered together; reset abandons any state with no lockout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NZONES; i++) begin
        st_q[i]  <= IDLE;
        cnt_q[i] <= '0;
      end
      heating    <= '0;
      cooling    <= '0;
      active_cnt <= '0;
      cfg_err    <= 1'b0;
    end else begin
      for (int i = 0; i < NZONES; i++) begin
        st_q[i]    <= st_d[i];
        cnt_q[i]   <= cnt_d[i];
        heating[i] <= (st_d[i] == HEAT);
        cooling[i] <= (st_d[i] == COOL);
      end
      active_cnt <= act_d;
      cfg_err    <= !cfg_ok;
    end
  end

endmodule

// File: tb/tb_ac_zone_ctrl.sv
// Bench for ac_zone_ctrl: directed scenarios plus a cycle-by-cycle reference model.
// Model tracks each zone as (state, cycles spent in state) and derives outputs from that.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_ac_zone_ctrl;

  localparam int NZ      = 4;
  localparam int TW      = 5;
  localparam int MIN_ON  = 8;
  localparam int LOCKOUT = 4;

  localparam int S_IDLE = 0;
  localparam int S_HEAT = 1;
  localparam int S_COOL = 2;
  localparam int S_HOLD = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              enable;
  logic [1:0]        mode;
  logic [TW-1:0]     heat_th;
  logic [TW-1:0]     target;
  logic [TW-1:0]     cool_th;
  logic [NZ*TW-1:0]  temperature;
  logic [NZ-1:0]     heating;
  logic [NZ-1:0]     cooling;
  logic [2:0]        active_cnt;
  logic              cfg_err;

  int tz [NZ];

  int n_chk  = 0;
  int n_fail = 0;

  int m_st  [NZ];
  int m_age [NZ];
  int m_cfg;

  ac_zone_ctrl #(.NZONES(NZ), .TW(TW), .MIN_ON(MIN_ON), .LOCKOUT(LOCKOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .mode        (mode),
    .heat_th     (heat_th),
    .target      (target),
    .cool_th     (cool_th),
    .temperature (temperature),
    .heating     (heating),
    .cooling     (cooling),
    .active_cnt  (active_cnt),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    temperature = '0;
    for (int z = 0; z < NZ; z++) temperature[z*TW +: TW] = tz[z][TW-1:0];
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference rules, stated in terms of how many cycles a zone has already spent in its state.
  function automatic int f_st(input int st, input int age, input int t, input int en,
                              input int md, input int ok, input int hth, input int tgt, input int cth);
    int ch;
    int cc;
    int spent;
    ch    = (en != 0 && ok != 0 && (md == 1 || md == 3)) ? 1 : 0;
    cc    = (en != 0 && ok != 0 && (md == 2 || md == 3)) ? 1 : 0;
    spent = age + 1;
    case (st)
      S_IDLE: begin
        if (ch != 0 && t <= hth) return S_HEAT;
        if (cc != 0 && t >= cth) return S_COOL;
        return S_IDLE;
      end
      S_HEAT: begin
        if (ch == 0) return S_HOLD;
        if (t >= tgt && spent >= MIN_ON) return S_HOLD;
        return S_HEAT;
      end
      S_COOL: begin
        if (cc == 0) return S_HOLD;
        if (t <= tgt && spent >= MIN_ON) return S_HOLD;
        return S_COOL;
      end
      default: return (spent >= LOCKOUT) ? S_IDLE : S_HOLD;
    endcase
  endfunction

  function automatic int f_age(input int st, input int nst, input int age);
    return (nst != st) ? 0 : age + 1;
  endfunction

  // Reference model update on every rising edge or asynchronous reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int z = 0; z < NZ; z++) begin
        m_st[z]  <= S_IDLE;
        m_age[z] <= 0;
      end
      m_cfg <= 0;
    end else begin
      m_cfg <= (int'(heat_th) < int'(target) && int'(target) < int'(cool_th)) ? 0 : 1;
      for (int z = 0; z < NZ; z++) begin
        m_st[z]  <= f_st(m_st[z], m_age[z], int'(temperature[z*TW +: TW]), int'(enable), int'(mode),
                         (int'(heat_th) < int'(target) && int'(target) < int'(cool_th)) ? 1 : 0,
                         int'(heat_th), int'(target), int'(cool_th));
        m_age[z] <= f_age(m_st[z],
                          f_st(m_st[z], m_age[z], int'(temperature[z*TW +: TW]), int'(enable), int'(mode),
                               (int'(heat_th) < int'(target) && int'(target) < int'(cool_th)) ? 1 : 0,
                               int'(heat_th), int'(target), int'(cool_th)),
                          m_age[z]);
      end
    end
  end

  function automatic int exp_vec(input int which);
    int v;
    v = 0;
    for (int z = 0; z < NZ; z++) if (m_st[z] == which) v = v | (1 << z);
    return v;
  endfunction

  function automatic int exp_active();
    int c;
    c = 0;
    for (int z = 0; z < NZ; z++) if (m_st[z] == S_HEAT || m_st[z] == S_COOL) c++;
    return c;
  endfunction

  // Every falling edge: DUT outputs against the model.
  always @(negedge clk) begin
    chk("model_heating", int'(heating), exp_vec(S_HEAT));
    chk("model_cooling", int'(cooling), exp_vec(S_COOL));
    chk("model_active_cnt", int'(active_cnt), exp_active());
    chk("model_cfg_err", int'(cfg_err), m_cfg);
    chk("heat_cool_exclusive", int'(heating & cooling), 0);
  end

  initial begin
    enable  = 1'b1;
    mode    = 2'b11;
    heat_th = 5'd18;
    target  = 5'd20;
    cool_th = 5'd22;
    for (int z = 0; z < NZ; z++) tz[z] = 20;
    #1 rst_n = 1'b0;
    step(2);
    chk("reset_heating", int'(heating), 0);
    chk("reset_cooling", int'(cooling), 0);
    chk("reset_active_cnt", int'(active_cnt), 0);
    chk("reset_cfg_err", int'(cfg_err), 0);
    rst_n = 1'b1;

    // Zone0: heat pulse, minimum on-time, lockout, then cooling.
    tz[0] = 18;
    step(1);
    chk("z0_heat_start", int'(heating[0]), 1);
    tz[0] = 25;
    for (int j = 1; j < 8; j++) begin
      step(1);
      chk("z0_heat_min_on", int'(heating[0]), 1);
    end
    step(1);
    chk("z0_heat_end_after_8", int'(heating[0]), 0);
    for (int j = 0; j < 3; j++) begin
      step(1);
      chk("z0_hold_no_cool", int'(cooling[0]), 0);
    end
    step(1);
    chk("z0_idle_after_hold", int'(cooling[0]), 0);
    step(1);
    chk("z0_cool_after_lockout", int'(cooling[0]), 1);
    tz[0] = 20;
    step(14);

    // Zone1: mode gating of cooling.
    mode  = 2'b01;
    tz[1] = 23;
    step(2);
    chk("z1_heat_only_no_cool", int'(cooling[1]), 0);
    mode = 2'b11;
    step(1);
    chk("z1_auto_cool_on", int'(cooling[1]), 1);
    mode = 2'b01;
    step(1);
    chk("z1_mode_drop_cool_off", int'(cooling[1]), 0);
    step(5);
    chk("z1_stays_off", int'(cooling[1]), 0);
    tz[1] = 20;
    mode  = 2'b11;
    step(2);

    // Zone2: dead band, then cool threshold equality, then target equality.
    for (int v = 19; v <= 21; v++) begin
      tz[2] = v;
      step(2);
      chk("z2_deadband_no_action", int'({heating[2], cooling[2]}), 0);
    end
    tz[2] = 22;
    step(1);
    chk("z2_cool_at_threshold", int'(cooling[2]), 1);
    tz[2] = 20;
    step(7);
    chk("z2_cool_min_on", int'(cooling[2]), 1);
    step(1);
    chk("z2_cool_exit_at_target", int'(cooling[2]), 0);
    step(6);

    // All zones heating, then global disable.
    for (int z = 0; z < NZ; z++) tz[z] = 10;
    step(1);
    chk("all_active_cnt_4", int'(active_cnt), 4);
    enable = 1'b0;
    step(1);
    chk("disable_active_cnt_0", int'(active_cnt), 0);
    chk("disable_heating_0", int'(heating), 0);
    enable = 1'b1;
    step(6);
    chk("reenable_heating_all", int'(heating), 15);

    // Invalid thresholds force HOLD; restored thresholds resume after lockout.
    heat_th = 5'd20;
    step(1);
    chk("badcfg_cfg_err", int'(cfg_err), 1);
    chk("badcfg_heating_off", int'(heating), 0);
    heat_th = 5'd18;
    step(1);
    chk("goodcfg_cfg_err", int'(cfg_err), 0);
    chk("goodcfg_still_hold", int'(heating), 0);
    step(4);
    chk("goodcfg_resume_heat", int'(heating), 15);

    // Asynchronous reset mid-HEAT, then immediate re-entry.
    step(2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_heating", int'(heating), 0);
    chk("async_reset_active", int'(active_cnt), 0);
    for (int z = 0; z < NZ; z++) tz[z] = 15;
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("post_reset_heat_first_edge", int'(heating), 15);
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
